// File: rtl/audio_pkg.sv
// Shared types for the audio voice scheduler: voice configuration payload,
// scheduler state encoding and the offset-binary silence level.
package audio_pkg;

    localparam int unsigned CFG_ADDR_W = 17;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] start_addr;
        logic [CFG_ADDR_W-1:0] end_addr;
        logic                  loop;
    } voice_cfg_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ACCUM   = 2'd2,
        PRESENT = 2'd3
    } sched_state_t;

    // Mid-scale code of an unsigned offset-binary sample.
    function automatic logic [31:0] silence_level(input int unsigned sample_w);
        return 32'(1) << (sample_w - 1);
    endfunction

endpackage

// File: rtl/audio_voice_ptr.sv
// One playback voice: holds its configuration, the current read pointer and
// the playing flag; advances once per issued read.
module audio_voice_ptr
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W = CFG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  voice_cfg_t        cfg_i,
    input  logic              play_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              active_o
);

    voice_cfg_t        cfg_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              active_q, active_d;

    // A one-shot voice parks on its end address once that read is issued.
    always_comb begin
        ptr_d    = ptr_q;
        active_d = active_q;
        if (load_i) begin
            ptr_d    = ADDR_W'(cfg_i.start_addr);
            active_d = play_i;
        end else if (adv_i) begin
            if (ptr_q != ADDR_W'(cfg_q.end_addr)) begin
                ptr_d = ptr_q + ADDR_W'(1);
            end else if (cfg_q.loop) begin
                ptr_d = ADDR_W'(cfg_q.start_addr);
            end else begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q    <= '0;
            ptr_q    <= '0;
            active_q <= 1'b0;
        end else begin
            if (load_i) begin
                cfg_q <= cfg_i;
            end
            ptr_q    <= ptr_d;
            active_q <= active_d;
        end
    end

    assign ptr_o    = ptr_q;
    assign active_o = active_q;

endmodule

// File: rtl/audio_voice_scheduler.sv
// Sample-tick driven voice mixer: reads each active voice from the sample ROM,
// sums them and hands the mix to the I2S serializer.
// Optional AUDIO_VOICE_SCHEDULER_OVERRUN_EN adds a dropped-tick counter.
module audio_voice_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned VOICES    = 4,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned SAMPLE_W  = 8,
    parameter int unsigned MIX_W     = SAMPLE_W + $clog2(VOICES),
    parameter int unsigned FRAME_DIV = 3
) (
    input  logic                       inp_clock,
    input  logic                       inp_reset,
    input  logic                       inp_frame,
    input  logic                       inp_cfg_valid,
    output logic                       out_cfg_ready,
    input  logic [$clog2(VOICES)-1:0]  inp_cfg_voice,
    input  logic [ADDR_W-1:0]          inp_cfg_start,
    input  logic [ADDR_W-1:0]          inp_cfg_end,
    input  logic                       inp_cfg_loop,
    input  logic                       inp_cfg_play,
    output logic                       out_mem_req,
    output logic [ADDR_W-1:0]          out_mem_addr,
    input  logic [SAMPLE_W-1:0]        inp_mem_data,
    output logic [MIX_W-1:0]           out_sample,
    output logic                       out_sample_valid,
    input  logic                       inp_sample_ready,
    output logic [VOICES-1:0]          out_voice_active
`ifdef AUDIO_VOICE_SCHEDULER_OVERRUN_EN
    ,
    output logic [15:0]                out_overrun_count
`endif
);

    localparam int unsigned V_W  = $clog2(VOICES);
    localparam int unsigned FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [MIX_W-1:0] SILENCE_MIX = MIX_W'(VOICES * silence_level(SAMPLE_W));
    localparam logic [MIX_W-1:0] SILENCE_ONE = MIX_W'(silence_level(SAMPLE_W));

    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              tick_c;
    sched_state_t      state_q;
    logic [V_W-1:0]    v_q;
    logic [MIX_W-1:0]  acc_q;
    logic              pend_act_q;
    logic [MIX_W-1:0]  sample_q;
    logic              valid_q;
    logic [MIX_W-1:0]  contrib_c;
    logic              cfg_fire_c;
    logic              issue_c;
    voice_cfg_t        cfg_c;
    logic [ADDR_W-1:0] ptr_c [VOICES];
    logic [VOICES-1:0] active_c;

    // Frame divider: one tick every FRAME_DIV word-clock frames.
    always_comb begin
        tick_c = inp_frame && (fcnt_q == FC_W'(FRAME_DIV - 1));
        fcnt_d = fcnt_q;
        if (inp_frame) begin
            fcnt_d = tick_c ? '0 : fcnt_q + FC_W'(1);
        end
    end

    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign out_cfg_ready = (state_q == IDLE) && !inp_reset;
    assign cfg_fire_c    = inp_cfg_valid && out_cfg_ready;
    assign issue_c       = (state_q == FETCH) && active_c[v_q];
    assign cfg_c         = '{start_addr: CFG_ADDR_W'(inp_cfg_start),
                             end_addr:   CFG_ADDR_W'(inp_cfg_end),
                             loop:       inp_cfg_loop};

    for (genvar i = 0; i < VOICES; i++) begin : g_voice
        audio_voice_ptr #(.ADDR_W(ADDR_W)) u_ptr (
            .clk_i    (inp_clock),
            .rst_i    (inp_reset),
            .load_i   (cfg_fire_c && (inp_cfg_voice == V_W'(i))),
            .cfg_i    (cfg_c),
            .play_i   (inp_cfg_play),
            .adv_i    (issue_c && (v_q == V_W'(i))),
            .ptr_o    (ptr_c[i]),
            .active_o (active_c[i])
        );
    end

    // Read data lags the request by one cycle; inactive voices add silence.
    assign contrib_c = pend_act_q ? MIX_W'(inp_mem_data) : SILENCE_ONE;

    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            state_q    <= IDLE;
            v_q        <= '0;
            acc_q      <= '0;
            pend_act_q <= 1'b0;
            sample_q   <= SILENCE_MIX;
            valid_q    <= 1'b0;
        end else begin
            pend_act_q <= issue_c;
            case (state_q)
                IDLE: begin
                    if (tick_c) begin
                        state_q <= FETCH;
                        v_q     <= '0;
                        acc_q   <= '0;
                    end
                end
                FETCH: begin
                    if (v_q != '0) begin
                        acc_q <= acc_q + contrib_c;
                    end
                    v_q <= v_q + V_W'(1);
                    if (v_q == V_W'(VOICES - 1)) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    sample_q <= acc_q + contrib_c;
                    valid_q  <= 1'b1;
                    state_q  <= PRESENT;
                end
                PRESENT: begin
                    if (inp_sample_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AUDIO_VOICE_SCHEDULER_OVERRUN_EN
    logic [15:0] overrun_q;

    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            overrun_q <= '0;
        end else if (tick_c && (state_q != IDLE) && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

    assign out_overrun_count = overrun_q;
`endif

    assign out_mem_req      = issue_c;
    assign out_mem_addr     = ptr_c[v_q];
    assign out_sample       = sample_q;
    assign out_sample_valid = valid_q;
    assign out_voice_active = active_c;

endmodule
